// File: rtl/alu_exec_unit.sv
// Execute-stage ALU for the LEGv8 datapath with valid/ready handshakes on both sides.
// Build option FAST_SHIFT_EN: single-cycle barrel-shifted LSL instead of the iterative shifter.
//
// state | meaning
// IDLE  | ready to accept an operation
// SHIFT | iterative LSL in progress (absent when FAST_SHIFT_EN is defined)
// DONE  | result valid on BusW/flags, held until out_ready
module alu_exec_unit #(
  parameter int WIDTH   = 64,
  parameter int SHAMT_W = 6
) (
  input  logic             CLK,
  input  logic             resetl,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUCtrl,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] BusW,
  output logic             Zero,
  output logic             Overflow,
  output logic             Illegal
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_ORR  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_PASS = 4'b0111;
  localparam logic [3:0] OP_LSL  = 4'b0011;

`ifdef FAST_SHIFT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
`endif

  state_t state, state_nxt;

  logic               accept;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   res;
  logic               res_ovf;
  logic               res_ill;
  logic [WIDTH-1:0]   b_eff;

  assign accept    = in_valid && in_ready;
  assign shamt     = BusB[SHAMT_W-1:0];
  assign in_ready  = resetl && (state == IDLE);
  assign out_valid = (state == DONE);

`ifndef FAST_SHIFT_EN
  logic [WIDTH-1:0]   work;
  logic [SHAMT_W-1:0] cnt;
  logic [WIDTH-1:0]   work_shl;
  assign work_shl = {work[WIDTH-2:0], 1'b0};
`endif

  // Single-cycle result path; the iterative build only uses the LSL arm for shamt == 0.
  always_comb begin
    res     = '0;
    res_ovf = 1'b0;
    res_ill = 1'b0;
    b_eff   = (ALUCtrl == OP_SUB) ? ~BusB : BusB;
    case (ALUCtrl)
      OP_AND:  res = BusA & BusB;
      OP_ORR:  res = BusA | BusB;
      OP_ADD, OP_SUB: begin
        res     = BusA + b_eff + ((ALUCtrl == OP_SUB) ? WIDTH'(1) : WIDTH'(0));
        res_ovf = (BusA[WIDTH-1] == b_eff[WIDTH-1]) && (res[WIDTH-1] != BusA[WIDTH-1]);
      end
      OP_PASS: res = BusB;
`ifdef FAST_SHIFT_EN
      OP_LSL:  res = BusA << shamt;
`else
      OP_LSL:  res = BusA;
`endif
      default: res_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef FAST_SHIFT_EN
          state_nxt = DONE;
`else
          state_nxt = ((ALUCtrl == OP_LSL) && (shamt != '0)) ? SHIFT : DONE;
`endif
        end
      end
`ifndef FAST_SHIFT_EN
      SHIFT: begin
        if (cnt == SHAMT_W'(1)) state_nxt = DONE;
      end
`endif
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!resetl) begin
      state    <= IDLE;
      BusW     <= '0;
      Zero     <= 1'b0;
      Overflow <= 1'b0;
      Illegal  <= 1'b0;
`ifndef FAST_SHIFT_EN
      work     <= '0;
      cnt      <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (accept && (state_nxt == DONE)) begin
        BusW     <= res;
        Zero     <= (res == '0);
        Overflow <= res_ovf;
        Illegal  <= res_ill;
      end
`ifndef FAST_SHIFT_EN
      if (accept && (state_nxt == SHIFT)) begin
        work <= BusA;
        cnt  <= shamt;
      end
      if (state == SHIFT) begin
        work <= work_shl;
        cnt  <= cnt - SHAMT_W'(1);
        // Last shift lands directly in BusW so Zero is taken from the final value.
        if (cnt == SHAMT_W'(1)) begin
          BusW     <= work_shl;
          Zero     <= (work_shl == '0);
          Overflow <= 1'b0;
          Illegal  <= 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: vector table for single operations plus
// hand-written sequences for back-pressure hold and reset during a shift.
module tb_alu_exec_unit;

  logic        CLK = 1'b0;
  logic        resetl = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  ALUCtrl = 4'b0000;
  logic [63:0] BusA = '0;
  logic [63:0] BusB = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] BusW;
  logic        Zero;
  logic        Overflow;
  logic        Illegal;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  alu_exec_unit #(.WIDTH(64), .SHAMT_W(6)) dut (
    .CLK(CLK), .resetl(resetl), .in_valid(in_valid), .in_ready(in_ready),
    .ALUCtrl(ALUCtrl), .BusA(BusA), .BusB(BusB), .out_valid(out_valid),
    .out_ready(out_ready), .BusW(BusW), .Zero(Zero), .Overflow(Overflow),
    .Illegal(Illegal)
  );

  typedef struct {
    logic [3:0]  ctrl;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] w;
    logic        z;
    logic        o;
    logic        i;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  function automatic int lsl_lat(int k);
`ifdef FAST_SHIFT_EN
    return 1;
`else
    return k + 1;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one op, wait for out_valid, return measured latency (accept edge to out_valid).
  task automatic issue(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b,
                       output int lat);
    int g;
    @(negedge CLK);
    g = 0;
    while (!in_ready && g < 200) begin
      @(negedge CLK);
      g++;
    end
    if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
    ALUCtrl  = c;
    BusA     = a;
    BusB     = b;
    in_valid = 1'b1;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    if (!out_valid) check("out_valid_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic consume();
    @(negedge CLK);
    out_ready = 1'b1;
    @(posedge CLK);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [63:0] held;

    vecs[0]  = '{4'b0010, 64'd5, 64'd7, 64'd12, 1'b0, 1'b0, 1'b0, 1};
    vecs[1]  = '{4'b0110, 64'd7, 64'd7, 64'd0, 1'b1, 1'b0, 1'b0, 1};
    vecs[2]  = '{4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1};
    vecs[3]  = '{4'b0110, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 1};
    vecs[4]  = '{4'b0011, 64'd1, 64'd63, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0, lsl_lat(63)};
    vecs[5]  = '{4'b0011, 64'h1234, 64'd0, 64'h1234, 1'b0, 1'b0, 1'b0, lsl_lat(0)};
    vecs[6]  = '{4'b0000, 64'hF0F0, 64'h0FF0, 64'h00F0, 1'b0, 1'b0, 1'b0, 1};
    vecs[7]  = '{4'b0001, 64'hF0F0, 64'h0FF0, 64'hFFF0, 1'b0, 1'b0, 1'b0, 1};
    vecs[8]  = '{4'b0111, 64'hF0F0, 64'h0FF0, 64'h0FF0, 1'b0, 1'b0, 1'b0, 1};
    vecs[9]  = '{4'b1111, 64'hF0F0, 64'h0FF0, 64'd0, 1'b1, 1'b0, 1'b1, 1};
    vecs[10] = '{4'b0011, 64'hF, 64'h104, 64'hF0, 1'b0, 1'b0, 1'b0, lsl_lat(4)};
    vecs[11] = '{4'b0110, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 1};
    vecs[12] = '{4'b0011, 64'h8000_0000_0000_0001, 64'd1, 64'd2, 1'b0, 1'b0, 1'b0, lsl_lat(1)};
    vecs[13] = '{4'b0011, 64'h8000_0000_0000_0000, 64'd1, 64'd0, 1'b1, 1'b0, 1'b0, lsl_lat(1)};
    vecs[14] = '{4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0, 1'b0, 1};

    // Reset held for 3 cycles
    repeat (3) @(posedge CLK);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busw", BusW, 64'd0);
    check("rst_flags", {61'd0, Zero, Overflow, Illegal}, 64'd0);
    @(negedge CLK);
    resetl = 1'b1;
    @(posedge CLK);
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);

    for (int v = 0; v < 15; v++) begin
      issue(vecs[v].ctrl, vecs[v].a, vecs[v].b, lat);
      check($sformatf("v%0d_busw", v), BusW, vecs[v].w);
      check($sformatf("v%0d_zero", v), 64'(Zero), 64'(vecs[v].z));
      check($sformatf("v%0d_ovf", v), 64'(Overflow), 64'(vecs[v].o));
      check($sformatf("v%0d_ill", v), 64'(Illegal), 64'(vecs[v].i));
      check($sformatf("v%0d_lat", v), 64'(lat), 64'(vecs[v].lat));
      check($sformatf("v%0d_in_ready_done", v), 64'(in_ready), 64'd0);
      consume();
      check($sformatf("v%0d_idle", v), {62'd0, in_ready, out_valid}, 64'd2);
    end

    // Back-pressure: result held, new request ignored while in DONE
    issue(4'b0010, 64'd1, 64'd2, lat);
    held = BusW;
    check("hold_first", held, 64'd3);
    @(negedge CLK);
    ALUCtrl  = 4'b0010;
    BusA     = 64'd100;
    BusB     = 64'd100;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge CLK);
      #1;
      check($sformatf("hold_busw_%0d", c), BusW, 64'd3);
      check($sformatf("hold_valid_%0d", c), {62'd0, out_valid, in_ready}, 64'd2);
    end
    @(negedge CLK);
    in_valid = 1'b0;
    consume();
    check("hold_released", {62'd0, in_ready, out_valid}, 64'd2);
    repeat (3) @(posedge CLK);
    #1;
    check("hold_no_ghost", 64'(out_valid), 64'd0);

    // Reset in the middle of a long shift discards the op
    @(negedge CLK);
    ALUCtrl  = 4'b0011;
    BusA     = 64'd1;
    BusB     = 64'd40;
    in_valid = 1'b1;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    resetl = 1'b0;
    @(posedge CLK);
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_busw", BusW, 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    @(negedge CLK);
    resetl = 1'b1;
    begin
      int seen = 0;
      for (int c = 0; c < 50; c++) begin
        @(posedge CLK);
        #1;
        if (out_valid) seen++;
      end
      check("midrst_no_result", 64'(seen), 64'd0);
    end
    check("midrst_idle", 64'(in_ready), 64'd1);
    issue(4'b0001, 64'hA0, 64'h05, lat);
    check("midrst_next_op", BusW, 64'hA5);
    check("midrst_next_lat", 64'(lat), 64'd1);
    consume();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
